// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: one requester's valid/ready write channel (addr + data)
interface regfile_wb_arbiter_if #(parameter int DW = 64, parameter int AW = 5);
  logic valid;
  logic ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  modport master(output valid, addr, data, input ready);
  modport slave(input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester register-file write-back arbiter, oldest-first with round-robin ties; WB_ZERO_DISCARD_EN suppresses writes to address 0
module regfile_wb_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   a,
  regfile_wb_arbiter_if.slave   b,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  busy
);
  logic a_full, b_full, a_old, same, rr;
  logic [AW-1:0] a_addr, b_addr, g_addr;
  logic [DW-1:0] a_data, b_data, g_data;
  logic ga, gb, acc_a, acc_b, tie, wr;
  // rr=0 favours A on a same-edge tie; a_old is only meaningful when same=0
  always_comb begin
    tie    = a_full & b_full & same;
    ga     = a_full & (!b_full | (same ? !rr : a_old));
    gb     = b_full & !ga;
    acc_a  = a.valid & a.ready;
    acc_b  = b.valid & b.ready;
    g_addr = ga ? a_addr : b_addr;
    g_data = ga ? a_data : b_data;
`ifdef WB_ZERO_DISCARD_EN
    wr     = (ga | gb) & (|g_addr);
`else
    wr     = ga | gb;
`endif
  end
  assign a.ready = !a_full | ga;
  assign b.ready = !b_full | gb;
  assign busy    = a_full | b_full | wr_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full  <= 1'b0;
      b_full  <= 1'b0;
      a_old   <= 1'b0;
      same    <= 1'b0;
      rr      <= 1'b0;
      a_addr  <= '0;
      a_data  <= '0;
      b_addr  <= '0;
      b_data  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      a_full <= acc_a | (a_full & !ga);
      b_full <= acc_b | (b_full & !gb);
      if (acc_a) begin
        a_addr <= a.addr;
        a_data <= a.data;
      end
      if (acc_b) begin
        b_addr <= b.addr;
        b_data <= b.data;
      end
      // a lone load makes the other (still-held) entry the older one
      if (acc_a & acc_b) same <= 1'b1;
      else if (acc_a) begin
        same  <= 1'b0;
        a_old <= 1'b0;
      end else if (acc_b) begin
        same  <= 1'b0;
        a_old <= 1'b1;
      end
      if (tie) rr <= !rr;
      wr_en <= wr;
      if (wr) begin
        wr_addr <= g_addr;
        wr_data <= g_data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter (honours WB_ZERO_DISCARD_EN)
module tb_regfile_wb_arbiter;
  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en, busy;
  logic [4:0] wr_addr;
  logic [63:0] wr_data;
  logic [63:0] rf [32];
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  regfile_wb_arbiter_if #(.DW(64), .AW(5)) ia ();
  regfile_wb_arbiter_if #(.DW(64), .AW(5)) ib ();
  regfile_wb_arbiter #(.DW(64), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .a(ia), .b(ib),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [4:0] ad, input logic [63:0] d);
    exp_t e;
    e.addr = ad;
    e.data = d;
    q.push_back(e);
  endtask
  task automatic drive_a(input logic v, input logic [4:0] ad, input logic [63:0] d);
    ia.valid = v;
    ia.addr  = ad;
    ia.data  = d;
  endtask
  task automatic drive_b(input logic v, input logic [4:0] ad, input logic [63:0] d);
    ib.valid = v;
    ib.addr  = ad;
    ib.data  = d;
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_n && wr_en) begin
          if (q.size() == 0) chk("unexpected_wr_en", {59'd0, wr_addr}, 64'hdead);
          else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_addr", {59'd0, wr_addr}, {59'd0, e.addr});
            chk("sb_data", wr_data, e.data);
            rf[wr_addr] = wr_data;
          end
        end
      end
    join_none
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    #12;
    chk("rst_wr_en", {63'd0, wr_en}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_wr_addr", {59'd0, wr_addr}, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_a_ready", {63'd0, ia.ready}, 1);
    chk("rst_b_ready", {63'd0, ib.ready}, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // single write latency and busy
    drive_a(1, 5, 64'h1234);
    push(5, 64'h1234);
    cyc();
    drive_a(0, 0, 0);
    chk("t1_wr_en_e1", {63'd0, wr_en}, 0);
    chk("t1_busy_e1", {63'd0, busy}, 1);
    cyc();
    chk("t1_wr_en_e2", {63'd0, wr_en}, 1);
    chk("t1_wr_addr_e2", {59'd0, wr_addr}, 5);
    cyc();
    chk("t1_wr_en_e3", {63'd0, wr_en}, 0);
    chk("t1_busy_e3", {63'd0, busy}, 0);
    chk("t1_hold_addr", {59'd0, wr_addr}, 5);
    // same-edge tie, then repeat with pointer flipped
    for (int r = 0; r < 2; r++) begin
      drive_a(1, 3, 64'hAA);
      drive_b(1, 4, 64'hBB);
      if (r == 0) begin
        push(3, 64'hAA);
        push(4, 64'hBB);
      end else begin
        push(4, 64'hBB);
        push(3, 64'hAA);
      end
      cyc();
      drive_a(0, 0, 0);
      drive_b(0, 0, 0);
      cyc();
      chk("t2_first_addr", {59'd0, wr_addr}, r == 0 ? 64'd3 : 64'd4);
      cyc();
      chk("t2_second_addr", {59'd0, wr_addr}, r == 0 ? 64'd4 : 64'd3);
      cyc();
      chk("t2_idle", {63'd0, wr_en}, 0);
    end
    // same address, acceptance order preserved
    drive_b(1, 7, 64'h1);
    push(7, 64'h1);
    push(7, 64'h2);
    cyc();
    drive_b(0, 0, 0);
    drive_a(1, 7, 64'h2);
    cyc();
    drive_a(0, 0, 0);
    chk("t3_b_first", wr_data, 64'h1);
    cyc();
    chk("t3_a_second", wr_data, 64'h2);
    cyc();
    chk("t3_rf7", rf[7], 64'h2);
    // back-to-back stream from A
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 9, 64'(i + 1));
      push(9, 64'(i + 1));
      chk("t4_a_ready", {63'd0, ia.ready}, 1);
      cyc();
      if (i > 0) chk("t4_stream", {63'(0), wr_en} << 32 | wr_data, (64'd1 << 32) | 64'(i));
    end
    drive_a(0, 0, 0);
    cyc();
    chk("t4_last", wr_data, 64'd4);
    chk("t4_last_en", {63'd0, wr_en}, 1);
    cyc();
    chk("t4_done", {63'd0, wr_en}, 0);
    // oldest-first must override the round-robin pointer
    drive_a(1, 10, 64'h1);
    drive_b(1, 11, 64'h2);
    push(10, 64'h1);
    push(11, 64'h2);
    push(12, 64'h3);
    push(13, 64'h4);
    cyc();
    drive_a(1, 12, 64'h3);
    drive_b(1, 13, 64'h4);
    chk("t7_b_blocked", {63'd0, ib.ready}, 0);
    cyc();
    drive_a(0, 0, 0);
    chk("t7_b_ready", {63'd0, ib.ready}, 1);
    cyc();
    drive_b(0, 0, 0);
    cyc();
    chk("t7_oldest_a", {59'd0, wr_addr}, 12);
    cyc();
    chk("t7_then_b", {59'd0, wr_addr}, 13);
    cyc();
    // reset between acceptance and grant
    drive_a(1, 6, 64'h55);
    cyc();
    drive_a(0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_wr_en", {63'd0, wr_en}, 0);
    chk("t5_rst_busy", {63'd0, busy}, 0);
    chk("t5_rst_ready", {63'd0, ia.ready}, 1);
    chk("t5_rst_addr", {59'd0, wr_addr}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_a(1, 8, 64'h77);
    push(8, 64'h77);
    cyc();
    drive_a(0, 0, 0);
    chk("t5_no_stale", {63'd0, wr_en}, 0);
    cyc();
    chk("t5_new_en", {63'd0, wr_en}, 1);
    chk("t5_new_addr", {59'd0, wr_addr}, 8);
    cyc();
    // address-zero write
    drive_a(1, 0, 64'hFF);
`ifndef WB_ZERO_DISCARD_EN
    push(0, 64'hFF);
`endif
    cyc();
    drive_a(0, 0, 0);
    cyc();
    chk("t6_ready", {63'd0, ia.ready}, 1);
`ifdef WB_ZERO_DISCARD_EN
    chk("t6_wr_en", {63'd0, wr_en}, 0);
    chk("t6_busy", {63'd0, busy}, 0);
`else
    chk("t6_wr_en", {63'd0, wr_en}, 1);
    chk("t6_wr_addr", {59'd0, wr_addr}, 0);
`endif
    cyc();
    cyc();
    chk("sb_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DW, default 64, data width of the register-file write port.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Reset  in  1  asynchronous, active-low; Reset=0 clears all state immediately.
REQ-005 A_Valid  in  1  requester A has a write pending.
REQ-006 A_Ready  out  1  the block accepts A this cycle.
REQ-007 A_Addr  in  AW  requester A destination register.
REQ-008 A_Data  in  DW  requester A write data.
REQ-009 B_Valid, B_Ready, B_Addr, B_Data  in/out/in/in  1/1/AW/DW  requester B, same meaning as A.
REQ-010 WrEn  out  1  register write enable to the register-file bank.
REQ-011 WrAddr  out  AW  register address for the write.
REQ-012 WrData  out  DW  data for the write.
REQ-013 Busy  out  1  high while either holding buffer is full or WrEn is high.

Function
REQ-014 A transfer SHALL occur on a rising edge where X_Valid=1 and X_Ready=1 (X = A or B); Addr and Data are captured into X's one-entry holding buffer.
REQ-015 X_Ready SHALL be combinational: X_Ready = (X buffer empty) OR (X buffer granted this cycle).
REQ-016 When exactly one buffer is full, that buffer SHALL be granted.
REQ-017 When both buffers are full, the buffer loaded on the earlier edge SHALL be granted (oldest-first).
REQ-018 When both buffers were loaded on the same edge, the requester named by the 1-bit round-robin pointer SHALL be granted; the pointer then SHALL move to the other requester.
REQ-019 On a grant, the granted entry SHALL load into the WrEn/WrAddr/WrData output registers on the same edge, and the buffer SHALL empty unless it is refilled on that edge.
REQ-020 Latency: a request accepted at edge k with no contention SHALL assert WrEn for exactly one cycle after edge k+1.
REQ-021 Sustained throughput SHALL be one write per cycle in total; each requester loses at most one cycle per contended write.
REQ-022 WrEn SHALL be 0 on any cycle with no grant; WrAddr/WrData SHALL then hold their last values.
REQ-023 Two pending writes to the same address SHALL be written in acceptance order, so the later value persists.
REQ-024 Busy SHALL be the registered-state OR of A full, B full, and WrEn.

Reset
REQ-025 While Reset=0: both buffers empty, age state cleared, round-robin pointer = A, WrEn=0, WrAddr=0, WrData=0, Busy=0, A_Ready=B_Ready=1.
REQ-026 Reset asserted mid-operation SHALL discard pending buffer contents; no WrEn pulse is issued for them after release.
REQ-027 The first edge after Reset rises SHALL accept new requests normally.

Configuration
REQ-028 Macro WB_ZERO_DISCARD_EN: when defined, a granted entry with Addr=0 SHALL consume its grant and empty its buffer, but WrEn SHALL stay 0 for that cycle (MIPS $zero is never written).
REQ-029 When WB_ZERO_DISCARD_EN is undefined, Addr=0 writes SHALL be issued like any other address.

Verification
REQ-030 Single A write, Addr=5, Data=0x1234 at edge 1 -> WrEn=1, WrAddr=5, WrData=0x1234 after edge 2 only; Busy returns to 0 after edge 3.
REQ-031 A and B valid on the same edge (A: 3/0xAA, B: 4/0xBB) with pointer=A -> A written after edge 2, B written after edge 3; a repeat of the same stimulus grants B first.
REQ-032 B accepted at edge 1, A at edge 2, both with Addr=7 (B: 0x1, A: 0x2) -> B written before A; the register ends at 0x2.
REQ-033 A_Valid held high for 4 edges with B idle, Data=1,2,3,4 -> four consecutive WrEn cycles in order; A_Ready stays 1 throughout.
REQ-034 Reset driven low between acceptance and grant -> WrEn=0 immediately and stays 0 after release; a new request after release is written normally.
REQ-035 Addr=0, Data=0xFF with WB_ZERO_DISCARD_EN defined -> WrEn stays 0 and Ready returns to 1; with the macro undefined -> WrEn=1, WrAddr=0.
